// File: rtl/fp_div_seq_pkg.sv
// Shared definitions for the sequential signed fixed-point divider.
//   FP_MAX / FP_MIN : saturation limits of the 32-bit S15.16 format
//   fp_div_state_t  : divider controller states
//   fp_div_status_t : per-result status flags {ovf, dbz}
//   fp_abs          : unsigned magnitude of a 32-bit signed value (MIN -> 2^31)
package fp_div_seq_pkg;

  localparam logic [31:0] FP_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] FP_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fp_div_state_t;

  typedef struct packed {
    logic ovf;
    logic dbz;
  } fp_div_status_t;

  function automatic logic [31:0] fp_abs(input logic signed [31:0] x);
    logic [31:0] r;
    r = x[31] ? (~x + 32'd1) : x;
    return r;
  endfunction

endpackage

// File: rtl/fp_div_seq_step.sv
// One combinational restoring-division iteration.
//   i_rem : partial remainder (always < i_div)
//   i_div : divisor magnitude
//   i_bit : next dividend bit shifted into the remainder
//   o_rem : next partial remainder
//   o_q   : resolved quotient bit
module fp_div_seq_step
  import fp_div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    // The shifted remainder is < 2*div, so when it reaches div the
    // difference is < div and fits in WIDTH bits without the carry.
    w_diff  = w_shift[WIDTH-1:0] - i_div;
    o_q     = (w_shift >= {1'b0, i_div});
    o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider: q = (a << FRAC_BITS) / b.
// Resolves RADIX_BITS quotient bits per cycle with a restoring chain,
// truncates toward zero, saturates on overflow and flags divide-by-zero.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_tag sampled at accept)
//   out_valid/out_ready : result handshake (out_q, out_tag, out_ovf, out_dbz)
module fp_div_seq
  import fp_div_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_BITS  = 16,
  parameter int RADIX_BITS = 1,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_q,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_ovf,
  output logic                 out_dbz
);

  localparam int DW = WIDTH + FRAC_BITS;
  localparam int N  = DW / RADIX_BITS;
  localparam int CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  // Saturation thresholds expressed on the DW-bit quotient magnitude.
  localparam logic [DW-1:0] MAG_MAX = {{(FRAC_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [DW-1:0] MAG_MIN = {{FRAC_BITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    return r;
  endfunction

  // Returns {ovf, q}: applies the sign and clamps to the representable range.
  function automatic logic [WIDTH:0] sat_q(input logic [DW-1:0] qm, input logic neg);
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   r;
    lo = qm[WIDTH-1:0];
    if (!neg && (qm > MAG_MAX))     r = {1'b1, MAXV};
    else if (neg && (qm > MAG_MIN)) r = {1'b1, MINV};
    else if (neg)                   r = {1'b0, ~lo + {{(WIDTH-1){1'b0}}, 1'b1}};
    else                            r = {1'b0, lo};
    return r;
  endfunction

  fp_div_state_t        r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_div;
  logic [WIDTH-1:0]     r_rem;
  logic [DW-1:0]        r_dq;
  logic                 r_sign;
  logic [WIDTH-1:0]     r_q;
  logic [TAG_WIDTH-1:0] r_tag;
  fp_div_status_t       r_stat;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_sat;
  logic [WIDTH-1:0]     w_rem [RADIX_BITS+1];
  logic [RADIX_BITS-1:0] w_qbits;
  logic [DW-1:0]        w_dq_nxt;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_state == ST_CALC) && (r_cnt == CW'(1));

  // Restoring chain: step k consumes dividend bit DW-1-k; r_dq shifts left
  // so dividend bits leave at the top while quotient bits enter at the bottom.
  assign w_rem[0] = r_rem;
  for (genvar k = 0; k < RADIX_BITS; k++) begin : g_step
    fp_div_seq_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (w_rem[k]),
      .i_div (r_div),
      .i_bit (r_dq[DW-1-k]),
      .o_rem (w_rem[k+1]),
      .o_q   (w_qbits[RADIX_BITS-1-k])
    );
  end

  assign w_dq_nxt = {r_dq[DW-RADIX_BITS-1:0], w_qbits};
  assign w_sat    = sat_q(w_dq_nxt, r_sign);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = (in_b == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_tag   <= '0;
      r_stat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tag <= in_tag;
        r_cnt <= CW'(N);
        if (in_b == '0) begin
          r_q    <= in_a[WIDTH-1] ? MINV : MAXV;
          r_stat <= '{ovf: 1'b0, dbz: 1'b1};
        end
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_q    <= w_sat[WIDTH-1:0];
          r_stat <= '{ovf: w_sat[WIDTH], dbz: 1'b0};
        end
      end
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_div  <= mag(in_b);
      r_rem  <= '0;
      r_dq   <= {mag(in_a), {FRAC_BITS{1'b0}}};
      r_sign <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end else if (r_state == ST_CALC) begin
      r_rem  <= w_rem[RADIX_BITS];
      r_dq   <= w_dq_nxt;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_q     = r_q;
  assign out_tag   = r_tag;
  assign out_ovf   = r_stat.ovf;
  assign out_dbz   = r_stat.dbz;

endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sel;
  logic        i_valid, o_ready;
  logic [31:0] i_a, i_b;
  logic [7:0]  i_tag;

  logic        rdy0, vld0, ov0, dz0;
  logic [31:0] q0;
  logic [7:0]  t0;
  logic        rdy1, vld1, ov1, dz1;
  logic [31:0] q1;
  logic [7:0]  t1;
  logic        rdy2, vld2, ov2, dz2;
  logic [23:0] q2;
  logic [7:0]  t2;

  logic        d_ready, d_valid, d_ovf, d_dbz;
  logic [31:0] d_q;
  logic [7:0]  d_tag;

  fp_div_seq u_dut0 (
    .clk(clk), .rst(rst), .in_valid(i_valid && (sel == 2'd0)), .in_ready(rdy0),
    .in_a(i_a), .in_b(i_b), .in_tag(i_tag), .out_valid(vld0), .out_ready(o_ready),
    .out_q(q0), .out_tag(t0), .out_ovf(ov0), .out_dbz(dz0));

  fp_div_seq #(.RADIX_BITS(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(i_valid && (sel == 2'd1)), .in_ready(rdy1),
    .in_a(i_a), .in_b(i_b), .in_tag(i_tag), .out_valid(vld1), .out_ready(o_ready),
    .out_q(q1), .out_tag(t1), .out_ovf(ov1), .out_dbz(dz1));

  fp_div_seq #(.WIDTH(24), .FRAC_BITS(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(i_valid && (sel == 2'd2)), .in_ready(rdy2),
    .in_a(i_a[23:0]), .in_b(i_b[23:0]), .in_tag(i_tag), .out_valid(vld2), .out_ready(o_ready),
    .out_q(q2), .out_tag(t2), .out_ovf(ov2), .out_dbz(dz2));

  always_comb begin
    case (sel)
      2'd1: begin d_ready = rdy1; d_valid = vld1; d_q = q1; d_tag = t1; d_ovf = ov1; d_dbz = dz1; end
      2'd2: begin d_ready = rdy2; d_valid = vld2; d_q = {8'h00, q2}; d_tag = t2; d_ovf = ov2; d_dbz = dz2; end
      default: begin d_ready = rdy0; d_valid = vld0; d_q = q0; d_tag = t0; d_ovf = ov0; d_dbz = dz0; end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: signed integer division on 64-bit values.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input int w, input int f,
                                output logic [31:0] q, output logic ovf, output logic dbz);
    longint mask, sa, sb, ma, mb, qm, maxv, magmin;
    mask   = (longint'(1) << w) - 1;
    maxv   = (longint'(1) << (w - 1)) - 1;
    magmin = longint'(1) << (w - 1);
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sa >= magmin) sa = sa - (longint'(1) << w);
    if (sb >= magmin) sb = sb - (longint'(1) << w);
    ovf = 1'b0;
    dbz = 1'b0;
    if (sb == 0) begin
      dbz = 1'b1;
      q = 32'(((sa < 0) ? -magmin : maxv) & mask);
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      qm = (ma << f) / mb;
      if ((sa < 0) != (sb < 0)) begin
        if (qm > magmin) begin ovf = 1'b1; qm = magmin; end
        q = 32'((-qm) & mask);
      end else begin
        if (qm > maxv) begin ovf = 1'b1; qm = maxv; end
        q = 32'(qm & mask);
      end
    end
  endfunction

  // One full transaction with out_ready high; lat = edges from accept to out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                       output logic [31:0] q, output logic [7:0] t, output logic ovf,
                       output logic dbz, output int lat);
    int guard;
    guard = 0;
    while (!d_ready && guard < 300) begin @(posedge clk); #1; guard++; end
    i_valid = 1'b1; i_a = a; i_b = b; i_tag = tag;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!d_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    q = d_q; t = d_tag; ovf = d_ovf; dbz = d_dbz;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tv[10];
  logic [31:0] pa[7], pb[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rq, eq;
    logic [7:0]  rt;
    logic        rov, rdz, eov, edz;
    int          lat, guard, acc, got, cyc, nv;
    int          acc_t[2];
    logic [31:0] gq[2];
    logic [7:0]  gt[2];
    logic        rb;

    tv[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, 1'b0, 48};
    tv[1] = '{32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 48};
    tv[2] = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 48};
    tv[3] = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 48};
    tv[4] = '{32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b1, 1'b0, 48};
    tv[5] = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 48};
    tv[6] = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 48};
    tv[7] = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 0};
    tv[8] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 0};
    tv[9] = '{32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0, 48};

    sel = 2'd0; rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_a = '0; i_b = '0; i_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", d_ready, 1);
    chk("reset out_valid", d_valid, 0);
    chk("reset out_q", d_q, 0);
    chk("reset out_tag", d_tag, 0);
    chk("reset out_ovf", d_ovf, 0);
    chk("reset out_dbz", d_dbz, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_op(tv[i].a, tv[i].b, 8'(8'h30 + i), rq, rt, rov, rdz, lat);
      chk($sformatf("vec%0d q", i), rq, tv[i].q);
      chk($sformatf("vec%0d ovf", i), rov, tv[i].ovf);
      chk($sformatf("vec%0d dbz", i), rdz, tv[i].dbz);
      chk($sformatf("vec%0d tag", i), rt, 8'(8'h30 + i));
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d valid drop", i), d_valid, 0);
    end

    // Back-pressure: result must hold while out_ready is low.
    o_ready = 1'b0;
    i_valid = 1'b1; i_a = 32'h0003_0000; i_b = 32'h0002_0000; i_tag = 8'h5A;
    @(posedge clk); #1;
    i_valid = 1'b0;
    guard = 0;
    while (!d_valid && guard < 300) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall q", d_q, 32'h0001_8000);
      chk("stall tag", d_tag, 8'h5A);
      chk("stall out_valid", d_valid, 1);
      chk("stall in_ready", d_ready, 0);
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", d_valid, 0);
    chk("release in_ready", d_ready, 1);

    // Back-to-back: in_valid stays high with new operands during CALC.
    i_valid = 1'b1; i_a = 32'h0001_0000; i_b = 32'h0002_0000; i_tag = 8'h11;
    acc = 0; got = 0; cyc = 0;
    while ((acc < 2 || got < 2) && cyc < 400) begin
      rb = d_ready;
      @(posedge clk); cyc++;
      #1;
      if (rb && i_valid) begin
        acc_t[acc] = cyc;
        acc++;
        if (acc == 1) begin i_a = 32'hFFFD_0000; i_b = 32'h0002_0000; i_tag = 8'h22; end
        else i_valid = 1'b0;
      end
      if (d_valid && got < 2) begin gq[got] = d_q; gt[got] = d_tag; got++; end
    end
    i_valid = 1'b0;
    chk("b2b results seen", got, 2);
    chk("b2b tag0", gt[0], 8'h11);
    chk("b2b q0", gq[0], 32'h0000_8000);
    chk("b2b tag1", gt[1], 8'h22);
    chk("b2b q1", gq[1], 32'hFFFE_8000);
    chk("b2b accept spacing", acc_t[1] - acc_t[0], 50);
    @(posedge clk); #1;

    // A divide-by-zero pulse during CALC must not be taken.
    i_valid = 1'b1; i_a = 32'h0001_0000; i_b = 32'h0002_0000; i_tag = 8'h33;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    i_valid = 1'b1; i_a = 32'h0005_0000; i_b = 32'h0; i_tag = 8'h44;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 6;
    while (!d_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("pulse latency", lat, 48);
    chk("pulse tag", d_tag, 8'h33);
    chk("pulse q", d_q, 32'h0000_8000);
    chk("pulse dbz", d_dbz, 0);
    nv = 0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #1; if (d_valid) nv++; end
    chk("pulse no extra result", nv, 0);

    // Reset in the middle of CALC.
    i_valid = 1'b1; i_a = 32'h0001_0000; i_b = 32'h0003_0000; i_tag = 8'h77;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre-reset in_ready", d_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset in_ready", d_ready, 1);
    chk("midreset out_valid", d_valid, 0);
    chk("midreset out_q", d_q, 0);
    chk("midreset out_tag", d_tag, 0);
    nv = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (d_valid) nv++; end
    chk("midreset no stale result", nv, 0);

    // Other configurations against the reference model.
    sel = 2'd1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      model(tv[i].a, tv[i].b, 32, 16, eq, eov, edz);
      do_op(tv[i].a, tv[i].b, 8'(i), rq, rt, rov, rdz, lat);
      chk($sformatf("r4 vec%0d q", i), rq, eq);
      chk($sformatf("r4 vec%0d ovf", i), rov, eov);
      chk($sformatf("r4 vec%0d dbz", i), rdz, edz);
      chk($sformatf("r4 vec%0d latency", i), lat, edz ? 0 : 12);
    end

    pa[0] = 32'h00_0100; pb[0] = 32'h00_0200;
    pa[1] = 32'hFF_FD00; pb[1] = 32'h00_0200;
    pa[2] = 32'h00_0100; pb[2] = 32'h00_0300;
    pa[3] = 32'hFF_FF00; pb[3] = 32'h00_0300;
    pa[4] = 32'h7F_FF00; pb[4] = 32'h00_0001;
    pa[5] = 32'h80_0000; pb[5] = 32'hFF_FF00;
    pa[6] = 32'h80_0000; pb[6] = 32'h00_0000;
    sel = 2'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      model(pa[i], pb[i], 24, 8, eq, eov, edz);
      do_op(pa[i], pb[i], 8'(8'hA0 + i), rq, rt, rov, rdz, lat);
      chk($sformatf("w24 vec%0d q", i), rq, eq);
      chk($sformatf("w24 vec%0d ovf", i), rov, eov);
      chk($sformatf("w24 vec%0d dbz", i), rdz, edz);
      chk($sformatf("w24 vec%0d tag", i), rt, 8'(8'hA0 + i));
      chk($sformatf("w24 vec%0d latency", i), lat, edz ? 0 : 32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
